// File: rtl/fsm_arb_pkg.sv
// Shared definitions for the round-robin control-sequence scheduler.
package fsm_arb_pkg;

  localparam int STATE_W = 2;
  typedef logic [STATE_W-1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t GO   = 2'd1;
  localparam state_t DONE = 2'd2;

  // Widest requester vector the onehot helper can produce; callers slice it down.
  localparam int ONEHOT_MAX = 32;
  typedef logic [ONEHOT_MAX-1:0] onehot_t;

  // One-hot decode of an index; out-of-range indices decode to all zeros.
  function automatic onehot_t onehot(input int unsigned idx);
    return (idx < ONEHOT_MAX) ? (onehot_t'(1) << idx) : '0;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at ptr, ptr+1, ... wrapping at N-1.
module rr_pick #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          valid,
  output logic [IW-1:0] idx
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  int             pos;

  // Rotate requests so bit i means requester (ptr+i) mod N, then take the lowest offset.
  always_comb begin
    dbl   = {req, req} >> ptr;
    rot   = dbl[N-1:0];
    valid = 1'b0;
    idx   = '0;
    pos   = 0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) begin
        valid = 1'b1;
        pos   = int'(ptr) + i;
        if (pos >= N) pos = pos - N;
        idx   = IW'(pos);
      end
    end
  end

endmodule

// File: rtl/fsm_arb.sv
// Round-robin scheduler sharing one IDLE->GO->DONE control sequence among N requesters.
// Handshake: req is a level sampled only in IDLE; once granted the transaction always runs
// to completion, and the owner sees gnt for GO+DONE and a single-cycle done in DONE.
module fsm_arb
  import fsm_arb_pkg::*;
#(
  parameter  int N         = 4,
  parameter  int GO_CYCLES = 1,
  localparam int IW        = $clog2(N),
  localparam int CW        = $clog2(GO_CYCLES + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] owner,
  output logic          busy,
  output logic          ctl,
  output logic [N-1:0]  done
);

  state_t        state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          pick_valid;
  logic [IW-1:0] pick_idx;
  onehot_t       owner_oh;

  rr_pick #(.N(N)) u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // State register plus arbitration pointer, owner and GO counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and datapath updates; the pointer only advances when a transaction finishes.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          owner_d = pick_idx;
          cnt_d   = CW'(GO_CYCLES - 1);
          state_d = GO;
        end
      end
      GO: begin
        if (cnt_q == '0) state_d = DONE;
        else             cnt_d   = cnt_q - CW'(1);
      end
      DONE: begin
        ptr_d   = (owner_q == IW'(N - 1)) ? '0 : owner_q + IW'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode from registered state and owner only; the illegal code drives everything low.
  always_comb begin
    owner_oh = onehot(32'(owner_q));
    gnt      = '0;
    done     = '0;
    busy     = 1'b0;
    ctl      = 1'b0;
    owner    = owner_q;
    case (state_q)
      IDLE: ;
      GO: begin
        busy = 1'b1;
        ctl  = 1'b1;
        gnt  = owner_oh[N-1:0];
      end
      DONE: begin
        busy = 1'b1;
        gnt  = owner_oh[N-1:0];
        done = owner_oh[N-1:0];
      end
      default: owner = '0;
    endcase
  end

endmodule

// File: tb/tb_fsm_arb.sv
// Bench for fsm_arb: three instances (N=4/G=1, N=4/G=3, N=3/G=1) against a
// transaction-timeline model, plus directed literal checks.
module tb_fsm_arb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] req_a [3];
  logic       rst_a [3] = '{1'b0, 1'b0, 1'b0};

  logic [3:0] g0, g1, d0, d1;
  logic [2:0] g2, d2;
  logic [1:0] o0, o1, o2;
  logic       b0, b1, b2, c0, c1, c2;

  logic [3:0] gnt_a [3];
  logic [3:0] done_a [3];
  logic [1:0] own_a [3];
  logic       busy_a [3];
  logic       ctl_a [3];

  always_comb begin
    gnt_a[0] = g0;  gnt_a[1] = g1;  gnt_a[2] = {1'b0, g2};
    done_a[0] = d0; done_a[1] = d1; done_a[2] = {1'b0, d2};
    own_a[0] = o0;  own_a[1] = o1;  own_a[2] = o2;
    busy_a[0] = b0; busy_a[1] = b1; busy_a[2] = b2;
    ctl_a[0] = c0;  ctl_a[1] = c1;  ctl_a[2] = c2;
  end

  fsm_arb #(.N(4), .GO_CYCLES(1)) u0 (
    .clk(clk), .rst_n(rst_a[0]), .req(req_a[0]),
    .gnt(g0), .owner(o0), .busy(b0), .ctl(c0), .done(d0));
  fsm_arb #(.N(4), .GO_CYCLES(3)) u1 (
    .clk(clk), .rst_n(rst_a[1]), .req(req_a[1]),
    .gnt(g1), .owner(o1), .busy(b1), .ctl(c1), .done(d1));
  fsm_arb #(.N(3), .GO_CYCLES(1)) u2 (
    .clk(clk), .rst_n(rst_a[2]), .req(req_a[2][2:0]),
    .gnt(g2), .owner(o2), .busy(b2), .ctl(c2), .done(d2));

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input int k, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s inst%0d: got %0h, expected %0h at %0t", name, k, act, exp, $time);
  endtask

  function automatic int nk(input int k);
    return (k == 2) ? 3 : 4;
  endfunction
  function automatic int gk(input int k);
    return (k == 1) ? 3 : 1;
  endfunction

  // Model: a transaction granted at edge t occupies slots t..t+G-1 (ctl) and t+G (done);
  // slot s is the interval after edge s. A new grant needs the previous slot to be free.
  int cyc = 0;
  int t_start [3] = '{-1, -1, -1};
  int m_own [3]   = '{0, 0, 0};
  int m_ptr [3]   = '{0, 0, 0};

  initial begin
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
      for (int k = 0; k < 3; k++) begin
        if (!rst_a[k]) begin
          t_start[k] = -1;
          m_own[k]   = 0;
          m_ptr[k]   = 0;
        end else begin
          if (t_start[k] >= 0 && cyc - 1 == t_start[k] + gk(k))
            m_ptr[k] = (m_own[k] + 1) % nk(k);
          if (!(t_start[k] >= 0 && cyc - 1 <= t_start[k] + gk(k)) && req_a[k] != 4'b0) begin
            for (int i = 0; i < nk(k); i++) begin
              if (req_a[k][(m_ptr[k] + i) % nk(k)]) begin
                m_own[k]   = (m_ptr[k] + i) % nk(k);
                t_start[k] = cyc;
                break;
              end
            end
          end
        end
      end
    end
  end

  // Every-cycle comparison of all outputs against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        bit in_go, in_done;
        int e_gnt, e_done, e_own;
        in_go   = rst_a[k] && t_start[k] >= 0 && cyc >= t_start[k] && cyc < t_start[k] + gk(k);
        in_done = rst_a[k] && t_start[k] >= 0 && cyc == t_start[k] + gk(k);
        e_gnt   = (in_go || in_done) ? (1 << m_own[k]) : 0;
        e_done  = in_done ? (1 << m_own[k]) : 0;
        e_own   = rst_a[k] ? m_own[k] : 0;
        chk("gnt",   k, int'(gnt_a[k]),  e_gnt);
        chk("done",  k, int'(done_a[k]), e_done);
        chk("owner", k, int'(own_a[k]),  e_own);
        chk("busy",  k, int'(busy_a[k]), int'(in_go || in_done));
        chk("ctl",   k, int'(ctl_a[k]),  int'(in_go));
      end
    end
  end

  int exp_order [5] = '{0, 1, 2, 3, 0};
  int order [5];
  int when [5];
  int got;
  logic [3:0] pend;

  initial begin
    for (int k = 0; k < 3; k++) req_a[k] = 4'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_gnt", 0, int'(g0), 0);
    chk("rst_busy", 0, int'(b0), 0);
    chk("rst_ctl", 1, int'(c1), 0);
    chk("rst_owner", 2, int'(o2), 0);
    for (int k = 0; k < 3; k++) rst_a[k] = 1'b1;

    // Idle with no requests
    repeat (10) @(negedge clk);
    chk("idle_busy", 0, int'(b0), 0);
    chk("idle_done", 1, int'(d1), 0);

    // Single request 0010, G=1
    req_a[0] = 4'b0010;
    @(negedge clk);
    chk("t2_gnt", 0, int'(g0), 4'b0010);
    chk("t2_ctl", 0, int'(c0), 1);
    chk("t2_owner", 0, int'(o0), 1);
    @(negedge clk);
    chk("t2_done", 0, int'(d0), 4'b0010);
    chk("t2_gnt_in_done", 0, int'(g0), 4'b0010);
    chk("t2_ctl_in_done", 0, int'(c0), 0);
    req_a[0] = 4'b0;
    @(negedge clk);
    chk("t2_idle_busy", 0, int'(b0), 0);
    chk("t2_idle_owner", 0, int'(o0), 1);

    // Reset clears the pointer (it is 2 here), then 1111 rotates 0,1,2,3,0
    rst_a[0] = 1'b0;
    @(negedge clk);
    rst_a[0] = 1'b1;
    req_a[0] = 4'b1111;
    got  = 0;
    pend = 4'b0;
    for (int i = 0; i < 60 && got < 5; i++) begin
      @(negedge clk);
      if (d0 != 4'b0) begin
        chk("rr_done_onehot", 0, $countones(d0), 1);
        for (int b = 0; b < 4; b++) if (d0[b]) order[got] = b;
        when[got] = i;
        got++;
        req_a[0] = req_a[0] & ~d0;
        pend = d0;
      end else if (pend != 4'b0) begin
        req_a[0] = req_a[0] | pend;
        pend = 4'b0;
      end
    end
    req_a[0] = 4'b0;
    chk("rr_count", 0, got, 5);
    for (int j = 0; j < got; j++) chk("rr_order", 0, order[j], exp_order[j]);
    for (int j = 1; j < got; j++) chk("rr_period", 0, when[j] - when[j-1], 3);
    repeat (2) @(negedge clk);

    // GO_CYCLES=3: ctl for exactly three cycles then one done
    req_a[1] = 4'b1000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("g3_ctl", 1, int'(c1), 1);
      chk("g3_nodone", 1, int'(d1), 0);
    end
    @(negedge clk);
    chk("g3_ctl_end", 1, int'(c1), 0);
    chk("g3_done", 1, int'(d1), 4'b1000);
    req_a[1] = 4'b0;
    @(negedge clk);
    chk("g3_idle", 1, int'(b1), 0);

    // Reset during the second GO cycle
    req_a[1] = 4'b0001;
    @(negedge clk);
    @(negedge clk);
    chk("mr_ctl_pre", 1, int'(c1), 1);
    #2;
    rst_a[1] = 1'b0;
    #1;
    chk("mr_ctl", 1, int'(c1), 0);
    chk("mr_gnt", 1, int'(g1), 0);
    chk("mr_busy", 1, int'(b1), 0);
    req_a[1] = 4'b0;
    repeat (2) @(negedge clk);
    rst_a[1] = 1'b1;
    req_a[1] = 4'b1100;
    @(negedge clk);
    chk("mr_owner", 1, int'(o1), 2);
    chk("mr_gnt2", 1, int'(g1), 4'b0100);
    repeat (2) @(negedge clk);
    @(negedge clk);
    chk("mr_done", 1, int'(d1), 4'b0100);
    req_a[1] = 4'b0;
    repeat (2) @(negedge clk);

    // N=3: move ptr to 2, then 011 wraps to 0; owner drops req mid-GO
    req_a[2] = 4'b0010;
    @(negedge clk);
    @(negedge clk);
    chk("n3_done1", 2, int'(d2), 3'b010);
    req_a[2] = 4'b0;
    @(negedge clk);
    req_a[2] = 4'b0011;
    @(negedge clk);
    chk("n3_owner", 2, int'(o2), 0);
    chk("n3_gnt", 2, int'(g2), 3'b001);
    req_a[2] = 4'b0;
    @(negedge clk);
    chk("n3_done", 2, int'(d2), 3'b001);
    @(negedge clk);
    chk("n3_idle", 2, int'(b2), 0);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fsm_arb.md
# fsm_arb

Round-robin scheduler that shares one IDLE→GO→DONE control sequence among N requesters. A granted requester gets exclusive use of the shared resource: `ctl` is held high for a programmable number of cycles, then a one-cycle `done` pulse goes back to that requester only. It sits between the requesting agents and the single-owner control line, so each agent need not run its own sequencer.

## Interface
- `N`, 4, number of requesters; must be ≥ 2.
- `GO_CYCLES`, 1, number of cycles `ctl` stays high per transaction; must be ≥ 1.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `req`  in  N  per-requester level request, sampled only in IDLE.
- `gnt`  out  N  one-hot grant, held high for the whole transaction (GO and DONE).
- `owner`  out  $clog2(N)  index of the current or last grantee.
- `busy`  out  1  high whenever state ≠ IDLE.
- `ctl`  out  1  shared control line, high only in GO.
- `done`  out  N  one-hot, one-cycle completion pulse to the owner, high only in DONE.

## Operation
- States, 2-bit encoding: IDLE=0, GO=1, DONE=2. Code 3 is illegal and goes to IDLE with all outputs 0.
- IDLE with `req` = 0: stay in IDLE.
- IDLE with `req` ≠ 0:
  - Pick the winner by round-robin from pointer `ptr`: the first set bit at index `ptr`, `ptr`+1, …, N−1, 0, …, `ptr`−1.
  - Register `owner` = winner, load `cnt` = GO_CYCLES−1, go to GO.
- GO: if `cnt` = 0, go to DONE; otherwise decrement `cnt`.
- DONE:
  - Set `ptr` = (`owner`+1) mod N; wrap N−1 → 0.
  - Go to IDLE unconditionally. There is always one IDLE cycle between transactions.
- Once granted, a transaction runs to completion. `req` changes during GO or DONE are ignored, including deassertion by the owner.
- Requester protocol: hold `req` until `done` is seen, then drop it at the next edge. If `req` is still high in the following IDLE cycle, it counts as a new request.
- Output decode is combinational from registered state, `owner` and `cnt` only. There is no combinational path from `req` to any output.
  - `gnt` = onehot(`owner`) when `busy`, else 0.
  - `done` = onehot(`owner`) when state = DONE, else 0.
- Reset values: state IDLE, `ptr` 0, `owner` 0, `cnt` 0.
  - All outputs are 0 in reset: `gnt`, `owner`, `busy`, `ctl`, `done`.
- Reset mid-transaction: `ctl` and `gnt` drop asynchronously. No `done` is issued. After reset, arbitration restarts from `ptr` = 0.
- Width rules:
  - `cnt` is $clog2(GO_CYCLES+1) bits and never underflows.
  - `ptr` and `owner` are $clog2(N) bits.
  - For N not a power of two, the `ptr` increment wraps explicitly at N−1.

## Timing
- `req` first seen high at edge t, state IDLE → GO at t. `gnt` and `busy` rise in cycle t+1.
- `ctl` is high in cycles t+1 … t+GO_CYCLES.
- DONE is cycle t+GO_CYCLES+1: `done` pulses and `gnt` is still high.
- IDLE is cycle t+GO_CYCLES+2. The earliest next GO is t+GO_CYCLES+3.
- Steady-state period per transaction with continuous requests: GO_CYCLES+2 cycles.
- A requester that is continuously requesting waits at most N−1 other transactions (starvation-free).

## Structure
- Package `fsm_arb_pkg` holds:
  - the state localparams IDLE/GO/DONE and the state width (2);
  - a `onehot` helper function used for `gnt` and `done`.
- One sub-module: `rr_pick`, a purely combinational round-robin priority picker.
  - Parameter: N.
  - Inputs: `req[N-1:0]`, `ptr`.
  - Outputs: `valid`, `idx`.
  - Reusable by other arbiters in the codebase.
- The top level holds the state register, `ptr`, `owner`, `cnt` and the output decode.

## Test plan
- Reset, then `req`=0 for 10 cycles → state stays IDLE and all outputs stay 0.
- N=4, GO_CYCLES=1, `req`=0010 from edge 0, dropped when `done` is seen:
  - cycle 1: `gnt`=0010, `ctl`=1, `owner`=1;
  - cycle 2: `done`=0010;
  - cycle 3: IDLE.
- `req`=1111 held continuously, with each requester dropping and re-raising after its `done` → grant order 0,1,2,3,0; `done` pulses every 3 cycles, never two bits at once.
- GO_CYCLES=3, single request → `ctl` high for exactly 3 consecutive cycles, then one `done` cycle.
- `rst_n` asserted during the second GO cycle → `ctl`/`gnt`/`busy` go to 0 immediately and no `done` appears. After release, `req`=1100 grants index 2, since `ptr` was reset to 0.
- N=3, `ptr` at 2 with `req`=011 → grant 0 (wrap path). Owner drops `req` mid-GO → transaction still completes with `done`=001.
